// File: rtl/t04_mul_pkg.sv
// Shared types and constants for the MUL sequencer in front of the shift-add multiplier.
// Optional signed support is enabled by defining T04_SIGNED_MUL_EN.
package t04_mul_pkg;

    // Sequencer states: wait for a request, pulse the multiplier, wait for ack, return result.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } mul_seq_state_t;

    // Operand width actually fed to the multiplier.
    localparam int MUL_OPW = 16;

    // Longest possible stay in WAIT: one cycle per multiplier bit plus the first WAIT cycle.
    localparam int MUL_MAX_WAIT = MUL_OPW + 1;

    // Data path width of the CPU register file and of the multiplier ports.
    localparam int MUL_DW = 32;

endpackage

// File: rtl/t04_mul_signfix.sv
// Conditional two's-complement negate. Used to take operand magnitudes before the
// unsigned multiplier and to restore the sign of the product afterwards.
// Only built when T04_SIGNED_MUL_EN is defined.
`ifdef T04_SIGNED_MUL_EN
module t04_mul_signfix
    import t04_mul_pkg::*;
#(
    parameter int W = MUL_OPW
) (
    input  logic [W-1:0] val_i,
    input  logic         neg_i,
    output logic [W-1:0] val_o
);

    // Negation wraps modulo 2^W, so the most negative operand yields its exact magnitude
    // when the result is read as unsigned.
    always_comb begin
        val_o = neg_i ? -val_i : val_i;
    end

endmodule
`endif

// File: rtl/t04_mul_sequencer.sv
// MUL sequencer: latches operands from the CPU, starts the external shift-add multiplier,
// stalls the pipeline until the multiplier acks, then returns the registered product with
// a one-cycle valid pulse. Define T04_SIGNED_MUL_EN to add sign-magnitude handling of
// signed operands around the unsigned multiplier.
// The multiplier itself lives outside this block; its active-high reset is ~nrst.
module t04_mul_sequencer
    import t04_mul_pkg::*;
#(
    parameter int OPW = MUL_OPW
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              req,
    input  logic              flush,
    input  logic              signed_op,
    input  logic [MUL_DW-1:0] op_a,
    input  logic [MUL_DW-1:0] op_b,
    output logic              freeze,
    output logic [MUL_DW-1:0] result,
    output logic              result_valid,
    output logic              mul,
    output logic [MUL_DW-1:0] multiplicand,
    output logic [MUL_DW-1:0] multiplier,
    input  logic [MUL_DW-1:0] product,
    input  logic              ack_mul
);

    mul_seq_state_t    state_q;
    logic [MUL_DW-1:0] result_q;
    logic [MUL_DW-1:0] multiplicand_q;
    logic [MUL_DW-1:0] multiplier_q;
    logic              neg_q;
    logic              rv_q;

    // Operand magnitudes and product sign derived from the current request.
    logic [OPW-1:0]    mag_a_d;
    logic [OPW-1:0]    mag_b_d;
    logic              neg_d;
    // Product after sign correction, captured into result_q on ack.
    logic [MUL_DW-1:0] result_d;
    logic              unused_ok;

`ifdef T04_SIGNED_MUL_EN
    logic [OPW-1:0] op_raw  [2];
    logic [OPW-1:0] op_mag  [2];
    logic           op_sign [2];

    assign op_raw[0] = op_a[OPW-1:0];
    assign op_raw[1] = op_b[OPW-1:0];

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_opfix
            // Sign only matters when the request is flagged as signed.
            assign op_sign[gi] = signed_op & op_raw[gi][OPW-1];

            t04_mul_signfix #(
                .W (OPW)
            ) u_opfix (
                .val_i (op_raw[gi]),
                .neg_i (op_sign[gi]),
                .val_o (op_mag[gi])
            );
        end
    endgenerate

    assign mag_a_d = op_mag[0];
    assign mag_b_d = op_mag[1];
    // A zero operand gives a zero product; keep it positive so no -0 path is exercised.
    assign neg_d   = (op_sign[0] ^ op_sign[1]) & (|op_mag[0]) & (|op_mag[1]);

    t04_mul_signfix #(
        .W (MUL_DW)
    ) u_resfix (
        .val_i (product),
        .neg_i (neg_q),
        .val_o (result_d)
    );

    assign unused_ok = ^{op_a[MUL_DW-1:OPW], op_b[MUL_DW-1:OPW]};
`else
    assign mag_a_d   = op_a[OPW-1:0];
    assign mag_b_d   = op_b[OPW-1:0];
    assign neg_d     = 1'b0;
    assign result_d  = product;
    assign unused_ok = ^{signed_op, neg_q, op_a[MUL_DW-1:OPW], op_b[MUL_DW-1:OPW]};
`endif

    // Sequencer FSM with its registered outputs; flush always returns to IDLE without a result.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q        <= IDLE;
            result_q       <= '0;
            multiplicand_q <= '0;
            multiplier_q   <= '0;
            neg_q          <= 1'b0;
            rv_q           <= 1'b0;
        end else begin
            rv_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req && !flush) begin
                        multiplicand_q <= {{(MUL_DW-OPW){1'b0}}, mag_a_d};
                        multiplier_q   <= {{(MUL_DW-OPW){1'b0}}, mag_b_d};
                        neg_q          <= neg_d;
                        state_q        <= ISSUE;
                    end
                end
                ISSUE: begin
                    // Any ack seen here belongs to a previous operation.
                    state_q <= flush ? IDLE : WAIT;
                end
                WAIT: begin
                    if (flush) begin
                        state_q <= IDLE;
                    end else if (ack_mul) begin
                        result_q <= result_d;
                        rv_q     <= 1'b1;
                        state_q  <= DONE;
                    end
                end
                DONE: begin
                    // The CPU advances on this edge; a new request is taken in the next IDLE.
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Stall: starts combinationally with the request, held until the DONE cycle.
    always_comb begin
        freeze = 1'b0;
        case (state_q)
            IDLE:        freeze = req;
            ISSUE, WAIT: freeze = 1'b1;
            default:     freeze = 1'b0;
        endcase
    end

    assign mul          = (state_q == ISSUE) && !flush;
    assign result_valid = rv_q && !flush;
    assign result       = result_q;
    assign multiplicand = multiplicand_q;
    assign multiplier   = multiplier_q;

endmodule

// File: tb/tb_t04_mul_sequencer.sv
// Bench for t04_mul_sequencer with a behavioural shift-add multiplier attached.
// Expected products are queued when a request is driven and checked when result_valid fires.
// Signed cases follow T04_SIGNED_MUL_EN when it is defined for the build.
module tb_t04_mul_sequencer;
    import t04_mul_pkg::*;

    logic        clk;
    logic        nrst;
    logic        req;
    logic        flush;
    logic        signed_op;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        freeze;
    logic [31:0] result;
    logic        result_valid;
    logic        mul;
    logic [31:0] multiplicand;
    logic [31:0] multiplier;
    logic [31:0] product;
    logic        ack_mul;

    int          n_checks = 0;
    int          n_errors = 0;
    int          n_txn    = 0;
    logic [31:0] exp_q [$];
    logic [31:0] last_res = 32'd0;

    t04_mul_sequencer #(
        .OPW (MUL_OPW)
    ) dut (
        .clk          (clk),
        .nrst         (nrst),
        .req          (req),
        .flush        (flush),
        .signed_op    (signed_op),
        .op_a         (op_a),
        .op_b         (op_b),
        .freeze       (freeze),
        .result       (result),
        .result_valid (result_valid),
        .mul          (mul),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .product      (product),
        .ack_mul      (ack_mul)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Shift-add multiplier: loads on a mul edge, then one bit of B per cycle.
    logic [31:0] m_acc;
    logic [31:0] m_a;
    logic [31:0] m_b;
    always @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            m_acc <= 32'd0;
            m_a   <= 32'd0;
            m_b   <= 32'd0;
        end else if (mul) begin
            m_acc <= 32'd0;
            m_a   <= {16'd0, multiplicand[15:0]};
            m_b   <= {16'd0, multiplier[15:0]};
        end else if (m_b != 32'd0) begin
            if (m_b[0]) m_acc <= m_acc + m_a;
            m_a <= m_a << 1;
            m_b <= m_b >> 1;
        end
    end
    assign product = m_acc;
    assign ack_mul = (m_b == 32'd0);

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [31:0] model_product(input logic [31:0] a, input logic [31:0] b,
                                                  input logic s);
        logic [15:0] a16;
        logic [15:0] b16;
        int          sa;
        int          sb;
        a16 = a[15:0];
        b16 = b[15:0];
        sa  = int'($signed(a16));
        sb  = int'($signed(b16));
`ifdef T04_SIGNED_MUL_EN
        if (s) return 32'(sa * sb);
`else
        if (s && (sa == sb + 1)) return 32'(a16) * 32'(b16);
`endif
        return 32'(a16) * 32'(b16);
    endfunction

    // Expected cycle of result_valid relative to the request cycle: 3 + bit length of |B|.
    function automatic int model_latency(input logic [31:0] b, input logic s);
        int m;
        int bl;
        m  = int'(b[15:0]);
`ifdef T04_SIGNED_MUL_EN
        if (s && b[15]) m = 65536 - m;
`else
        if (s) m = int'(b[15:0]);
`endif
        bl = 0;
        for (int i = 0; i < 17; i++) if (m[i]) bl = i + 1;
        return 3 + bl;
    endfunction

    // Scoreboard: every result_valid must match the oldest queued product.
    always @(negedge clk) begin
        if (nrst && result_valid) begin
            check_eq("sb_pending", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                logic [31:0] e;
                e = exp_q.pop_front();
                check_eq("result", result, e);
                last_res = e;
                n_txn++;
                $display("txn %0d: result=0x%08h expected=0x%08h", n_txn, result, e);
            end
        end
    end

    // Starts at #1 after an edge (cycle 0) and ends at #1 after the edge closing DONE.
    task automatic run_mul(input logic [31:0] a, input logic [31:0] b, input logic s);
        int got;
        int mul_cnt;
        int frz_low;
        int lat;
        lat      = model_latency(b, s);
        req      = 1'b1;
        op_a     = a;
        op_b     = b;
        signed_op = s;
        exp_q.push_back(model_product(a, b, s));
        got     = -1;
        mul_cnt = 0;
        frz_low = 0;
        for (int k = 0; k < MUL_MAX_WAIT + 5; k++) begin
            @(negedge clk);
            if (k == 0) check_eq("frz_req", 32'(freeze), 32'd1);
            if (mul) mul_cnt++;
            if (result_valid) begin
                got = k;
                check_eq("frz_done", 32'(freeze), 32'd0);
                break;
            end
            if (!freeze) frz_low++;
            if (k == 1) begin
                op_a      = $urandom;
                op_b      = $urandom;
                signed_op = ~signed_op;
            end
            @(posedge clk);
            #1;
        end
        check_eq("latency", 32'(got), 32'(lat));
        check_eq("mul_cnt", 32'(mul_cnt), 32'd1);
        check_eq("frz_hold", 32'(frz_low), 32'd0);
        @(posedge clk);
        #1;
        req = 1'b0;
    endtask

    // Request, then flush at the given cycle with req dropped by the CPU.
    task automatic run_flush(input logic [31:0] a, input logic [31:0] b, input int at_cycle);
        int rv_seen;
        req       = 1'b1;
        op_a      = a;
        op_b      = b;
        signed_op = 1'b0;
        for (int k = 0; k < at_cycle; k++) begin
            @(posedge clk);
            #1;
        end
        flush = 1'b1;
        req   = 1'b0;
        @(negedge clk);
        check_eq("flush_mul", 32'(mul), 32'd0);
        @(posedge clk);
        #1;
        flush = 1'b0;
        @(negedge clk);
        check_eq("flush_frz", 32'(freeze), 32'd0);
        rv_seen = 0;
        for (int k = 0; k < MUL_MAX_WAIT + 2; k++) begin
            if (result_valid) rv_seen++;
            @(negedge clk);
        end
        check_eq("flush_rv", 32'(rv_seen), 32'd0);
        check_eq("flush_res", result, last_res);
        @(posedge clk);
        #1;
    endtask

    initial begin
        nrst      = 1'b0;
        req       = 1'b0;
        flush     = 1'b0;
        signed_op = 1'b0;
        op_a      = 32'd0;
        op_b      = 32'd0;
        #12;
        check_eq("rst_ctl", {29'd0, freeze, mul, result_valid}, 32'd0);
        check_eq("rst_result", result, 32'd0);
        check_eq("rst_mcand", multiplicand, 32'd0);
        check_eq("rst_mplier", multiplier, 32'd0);
        @(negedge clk);
        nrst = 1'b1;
        @(posedge clk);
        #1;

        run_mul(32'd7, 32'd6, 1'b0);
        run_mul(32'h0000_1234, 32'd0, 1'b0);
        run_mul(32'hFFFF_FFFF, 32'h0001_FFFF, 1'b0);

        // Flush in the third WAIT cycle, then a normal request.
        run_flush(32'd100, 32'd200, 4);
        run_mul(32'd5, 32'd5, 1'b0);
        // Flush while in ISSUE: the start pulse must not appear.
        run_flush(32'd9, 32'd11, 1);

        // Back-to-back: the second request is driven in the IDLE cycle right after DONE.
        run_mul(32'd3, 32'd3, 1'b0);
        run_mul(32'd4, 32'd4, 1'b0);

        for (int i = 0; i < 6; i++) begin
            run_mul($urandom, $urandom, 1'b0);
        end

        run_mul(32'h0000_FFFD, 32'd5, 1'b1);
        run_mul(32'h0000_8000, 32'h0000_8000, 1'b1);
        run_mul(32'd0, 32'h0000_FFF9, 1'b1);
        run_mul(32'h0000_FFFD, 32'd5, 1'b0);
        run_mul(32'h0000_0009, 32'h0000_FFFE, 1'b1);

        // Asynchronous reset in the middle of WAIT.
        req       = 1'b1;
        op_a      = 32'h0000_00FF;
        op_b      = 32'h0000_FFFF;
        signed_op = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        @(negedge clk);
        check_eq("latch_mcand", multiplicand, 32'h0000_00FF);
        check_eq("latch_mplier", multiplier, 32'h0000_FFFF);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        nrst = 1'b0;
        req  = 1'b0;
        #1;
        check_eq("arst_ctl", {29'd0, freeze, mul, result_valid}, 32'd0);
        check_eq("arst_result", result, 32'd0);
        check_eq("arst_mcand", multiplicand, 32'd0);
        check_eq("arst_mplier", multiplier, 32'd0);
        last_res = 32'd0;
        @(negedge clk);
        nrst = 1'b1;
        @(posedge clk);
        #1;
        run_mul(32'd2, 32'd3, 1'b0);

        repeat (3) @(negedge clk);
        check_eq("sb_drain", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
